// File: rtl/modulo_dispensador_rolhas.sv
// Cork dispenser: consumer side of the cork buffer.
// Owns the main cork count (reg_r), accepts batch loads from the cork
// loader and removes one cork per rising edge of the sealing request,
// driving the feed actuator for FEED_CYCLES cycles per cork.
// Optional feature macro: AUTO_REFILL_EN adds the refill_req output with
// hysteresis between MIN_ROLHAS and CAP-10.
module modulo_dispensador_rolhas #(
    parameter int WIDTH       = 7,
    parameter int CAP         = 99,
    parameter int MIN_ROLHAS  = 20,
    parameter int FEED_CYCLES = 4
) (
    input  logic             clk,
    input  logic             Nclr,
    input  logic             req,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_qty,
    output logic             load_ack,
    output logic             load_err,
    output logic             feed,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] reg_r,
    output logic             ro,
    output logic             min_signal
`ifdef AUTO_REFILL_EN
    ,
    output logic             refill_req
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // A single-cycle feed still needs a 1-bit counter to keep widths legal.
    localparam int               CNT_W     = (FEED_CYCLES > 1) ? $clog2(FEED_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(FEED_CYCLES - 1);
    localparam logic [WIDTH:0]   CAP_EXT   = (WIDTH + 1)'(CAP);
    localparam logic [WIDTH-1:0] MIN_VAL   = WIDTH'(MIN_ROLHAS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] feed_cnt_q, feed_cnt_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] reg_r_q, reg_r_d;
    logic             load_ack_q, load_ack_d;
    logic             load_err_q, load_err_d;

    logic             req_rise;
    logic             dec;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   nxt;
    logic             accept;

    assign req_rise   = req & ~req_q;
    assign ro         = (reg_r_q == '0);
    assign min_signal = (reg_r_q < MIN_VAL);
    assign busy       = (state_q == S_FEED) || (state_q == S_DONE);
    assign reg_r      = reg_r_q;
    assign load_ack   = load_ack_q;
    assign load_err   = load_err_q;

    // Count update: load and decrement combine in one extra-wide sum so a
    // load arriving in the DONE cycle is judged against the post-dispense count.
    always_comb begin
        dec     = (state_q == S_DONE);
        add_ext = load_valid ? {1'b0, load_qty} : '0;
        nxt     = {1'b0, reg_r_q} + add_ext - {{WIDTH{1'b0}}, dec};
        accept  = load_valid && (nxt <= CAP_EXT);
        req_d   = req;
        if (accept) begin
            reg_r_d = nxt[WIDTH-1:0];
        end else begin
            reg_r_d = reg_r_q - {{(WIDTH-1){1'b0}}, dec};
        end
        load_ack_d = accept;
        load_err_d = load_valid && !accept;
    end

    // Dispense FSM: next state, feed counter and Moore outputs.
    always_comb begin
        state_d    = state_q;
        feed_cnt_d = feed_cnt_q;
        feed       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                feed_cnt_d = '0;
                if (req_rise) begin
                    state_d = ro ? S_FAULT : S_FEED;
                end
            end
            S_FEED: begin
                feed = 1'b1;
                if (feed_cnt_q == FEED_LAST) begin
                    state_d = S_DONE;
                end else begin
                    feed_cnt_d = feed_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                // Request edges are dropped here; leave once corks exist.
                if (!ro) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any cork in flight.
    always_ff @(posedge clk) begin
        if (!Nclr) begin
            state_q    <= S_IDLE;
            feed_cnt_q <= '0;
            req_q      <= 1'b0;
            reg_r_q    <= '0;
            load_ack_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            feed_cnt_q <= feed_cnt_d;
            req_q      <= req_d;
            reg_r_q    <= reg_r_d;
            load_ack_q <= load_ack_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef AUTO_REFILL_EN
    localparam logic [WIDTH-1:0] REFILL_HI = WIDTH'(CAP - 10);

    logic refill_req_q, refill_req_d;

    // Refill request with hysteresis: set when low, cleared when nearly full.
    always_comb begin
        refill_req_d = refill_req_q;
        if (reg_r_q < MIN_VAL) begin
            refill_req_d = 1'b1;
        end else if (reg_r_q >= REFILL_HI) begin
            refill_req_d = 1'b0;
        end
    end

    // Refill request register.
    always_ff @(posedge clk) begin
        if (!Nclr) begin
            refill_req_q <= 1'b0;
        end else begin
            refill_req_q <= refill_req_d;
        end
    end

    assign refill_req = refill_req_q;
`endif

endmodule

// File: tb/tb_modulo_dispensador_rolhas.sv
// Self-checking bench for modulo_dispensador_rolhas (default parameters).
module tb_modulo_dispensador_rolhas;

    typedef struct {
        bit ack;
        bit err;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       Nclr = 1'b0;
    logic       req = 1'b0;
    logic       load_valid = 1'b0;
    logic [6:0] load_qty = '0;
    logic       load_ack, load_err, feed, done, busy, ro, min_signal;
    logic [6:0] reg_r;
`ifdef AUTO_REFILL_EN
    logic       refill_req;
`endif

    int   checks = 0;
    int   failures = 0;
    int   model = 0;
    exp_t load_q[$];
    int   disp_q[$];

    modulo_dispensador_rolhas dut (
        .clk       (clk),
        .Nclr      (Nclr),
        .req       (req),
        .load_valid(load_valid),
        .load_qty  (load_qty),
        .load_ack  (load_ack),
        .load_err  (load_err),
        .feed      (feed),
        .done      (done),
        .busy      (busy),
        .reg_r     (reg_r),
        .ro        (ro),
        .min_signal(min_signal)
`ifdef AUTO_REFILL_EN
        ,
        .refill_req(refill_req)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Nclr = 1'b0;
        req = 1'b0;
        load_valid = 1'b0;
        tick();
        Nclr = 1'b1;
        tick();
        model = 0;
    endtask

    // Drives one load for a cycle and records the expected response.
    task automatic do_load(input int qty, input bit dec_now);
        int   nxt;
        exp_t e;
        nxt = model + qty - (dec_now ? 1 : 0);
        if (nxt <= 99) begin
            e.ack = 1'b1; e.err = 1'b0; e.cnt = nxt;
        end else begin
            e.ack = 1'b0; e.err = 1'b1; e.cnt = model - (dec_now ? 1 : 0);
        end
        model = e.cnt;
        load_q.push_back(e);
        load_valid = 1'b1;
        load_qty = 7'(qty);
        tick();
        load_valid = 1'b0;
        load_qty = '0;
        $display("load qty=%0d -> ack=%0b err=%0b reg_r=%0d", qty, load_ack, load_err, reg_r);
    endtask

    task automatic test_reset();
        Nclr = 1'b0;
        req = 1'b1;
        load_valid = 1'b1;
        load_qty = 7'd10;
        tick();
        tick();
        $display("reset: reg_r=%0d feed=%0b done=%0b ack=%0b ro=%0b min=%0b", reg_r, feed, done, load_ack, ro, min_signal);
        checks++; if (reg_r !== 7'd0) begin failures++; $display("FAIL reset_reg_r: got %0d expected 0", reg_r); end
        checks++; if (feed !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_fsm_out: got feed=%0b done=%0b busy=%0b expected 0", feed, done, busy); end
        checks++; if (load_ack !== 1'b0 || load_err !== 1'b0) begin failures++; $display("FAIL reset_load_out: got ack=%0b err=%0b expected 0", load_ack, load_err); end
        checks++; if (ro !== 1'b1 || min_signal !== 1'b1) begin failures++; $display("FAIL reset_flags: got ro=%0b min=%0b expected 1 1", ro, min_signal); end
        req = 1'b0;
        load_valid = 1'b0;
        load_qty = '0;
        Nclr = 1'b1;
        tick();
        model = 0;
    endtask

    task automatic test_load_dispense();
        exp_t e;
        int   cyc, feed_n, exp_cnt;
        bit   got;
        do_load(30, 1'b0);
        e = load_q.pop_front();
        checks++; if (load_ack !== e.ack || load_err !== e.err) begin failures++; $display("FAIL load30_resp: got ack=%0b err=%0b expected ack=%0b err=%0b", load_ack, load_err, e.ack, e.err); end
        checks++; if (reg_r !== 7'(e.cnt)) begin failures++; $display("FAIL load30_reg_r: got %0d expected %0d", reg_r, e.cnt); end
        req = 1'b1;
        disp_q.push_back(model - 1);
        model--;
        cyc = 0; feed_n = 0; got = 0;
        while (cyc < 20 && !got) begin
            tick();
            cyc++;
            if (done) got = 1;
            else if (feed) feed_n++;
        end
        $display("dispense: done after %0d cycles, feed cycles=%0d", cyc, feed_n);
        checks++; if (!got || cyc != 5) begin failures++; $display("FAIL dispense_latency: got %0d cycles (done=%0b) expected 5", cyc, got); end
        checks++; if (feed_n != 4) begin failures++; $display("FAIL dispense_feed_len: got %0d expected 4", feed_n); end
        tick();
        exp_cnt = disp_q.pop_front();
        checks++; if (reg_r !== 7'(exp_cnt) || done !== 1'b0) begin failures++; $display("FAIL dispense_reg_r: got %0d done=%0b expected %0d done=0", reg_r, done, exp_cnt); end
        checks++; if (min_signal !== 1'b0) begin failures++; $display("FAIL dispense_min: got %0b expected 0", min_signal); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        int   qtys[4] = '{66, 5, 4, 0};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            do_load(qtys[i], 1'b0);
            e = load_q.pop_front();
            checks++; if (load_ack !== e.ack || load_err !== e.err) begin failures++; $display("FAIL overflow_resp[%0d]: got ack=%0b err=%0b expected ack=%0b err=%0b", i, load_ack, load_err, e.ack, e.err); end
            checks++; if (reg_r !== 7'(e.cnt)) begin failures++; $display("FAIL overflow_reg_r[%0d]: got %0d expected %0d", i, reg_r, e.cnt); end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int   cyc;
        bit   got;
        req = 1'b1;
        cyc = 0; got = 0;
        while (cyc < 20 && !got) begin
            tick();
            cyc++;
            if (done) got = 1;
        end
        checks++; if (!got) begin failures++; $display("FAIL simul_done: got no done within 20 cycles expected done"); end
        do_load(1, 1'b1);
        e = load_q.pop_front();
        checks++; if (load_ack !== e.ack || load_err !== e.err) begin failures++; $display("FAIL simul_resp: got ack=%0b err=%0b expected ack=%0b err=%0b", load_ack, load_err, e.ack, e.err); end
        checks++; if (reg_r !== 7'(e.cnt)) begin failures++; $display("FAIL simul_reg_r: got %0d expected %0d", reg_r, e.cnt); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_done_and_ack();
        exp_t e;
        int   exp_cnt;
        req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        // Last FEED cycle: a zero-size load here pulses load_ack with done.
        do_load(0, 1'b0);
        e = load_q.pop_front();
        disp_q.push_back(model - 1);
        model--;
        checks++; if (done !== 1'b1 || load_ack !== e.ack) begin failures++; $display("FAIL done_ack_same: got done=%0b ack=%0b expected done=1 ack=%0b", done, load_ack, e.ack); end
        tick();
        exp_cnt = disp_q.pop_front();
        $display("done+ack: reg_r=%0d", reg_r);
        checks++; if (reg_r !== 7'(exp_cnt)) begin failures++; $display("FAIL done_ack_reg_r: got %0d expected %0d", reg_r, exp_cnt); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_empty();
        exp_t e;
        int   feeds, dones, cyc, exp_cnt;
        bit   got;
        do_reset();
        req = 1'b1;
        feeds = 0; dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (feed || busy) feeds++;
            if (done) dones++;
        end
        $display("empty req: feeds=%0d dones=%0d ro=%0b", feeds, dones, ro);
        checks++; if (feeds != 0 || dones != 0) begin failures++; $display("FAIL empty_no_feed: got feeds=%0d dones=%0d expected 0 0", feeds, dones); end
        checks++; if (ro !== 1'b1) begin failures++; $display("FAIL empty_ro: got %0b expected 1", ro); end
        req = 1'b0;
        tick();
        do_load(12, 1'b0);
        e = load_q.pop_front();
        checks++; if (load_ack !== e.ack || reg_r !== 7'(e.cnt)) begin failures++; $display("FAIL empty_load: got ack=%0b reg_r=%0d expected ack=%0b reg_r=%0d", load_ack, reg_r, e.ack, e.cnt); end
        // Still in FAULT this cycle: this edge must be dropped.
        req = 1'b1;
        feeds = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (feed) feeds++;
        end
        checks++; if (feeds != 0) begin failures++; $display("FAIL fault_edge_dropped: got feeds=%0d expected 0", feeds); end
        req = 1'b0;
        tick();
        req = 1'b1;
        disp_q.push_back(model - 1);
        model--;
        cyc = 0; got = 0;
        while (cyc < 20 && !got) begin
            tick();
            cyc++;
            if (done) got = 1;
        end
        tick();
        exp_cnt = disp_q.pop_front();
        $display("after fault dispense: reg_r=%0d min=%0b", reg_r, min_signal);
        checks++; if (!got || reg_r !== 7'(exp_cnt)) begin failures++; $display("FAIL fault_recover: got done=%0b reg_r=%0d expected done=1 reg_r=%0d", got, reg_r, exp_cnt); end
        checks++; if (min_signal !== 1'b1) begin failures++; $display("FAIL fault_min: got %0b expected 1", min_signal); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_held_req_and_reset();
        exp_t e;
        int   dones, feeds, exp_cnt;
        do_reset();
        do_load(3, 1'b0);
        e = load_q.pop_front();
        checks++; if (reg_r !== 7'(e.cnt)) begin failures++; $display("FAIL held_load: got %0d expected %0d", reg_r, e.cnt); end
        req = 1'b1;
        disp_q.push_back(model - 1);
        model--;
        dones = 0; feeds = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
            if (feed) feeds++;
        end
        exp_cnt = disp_q.pop_front();
        $display("held req: dones=%0d feeds=%0d reg_r=%0d", dones, feeds, reg_r);
        checks++; if (dones != 1 || feeds != 4) begin failures++; $display("FAIL held_single: got dones=%0d feeds=%0d expected 1 4", dones, feeds); end
        checks++; if (reg_r !== 7'(exp_cnt)) begin failures++; $display("FAIL held_reg_r: got %0d expected %0d", reg_r, exp_cnt); end
        req = 1'b0;
        tick();
        req = 1'b1;
        tick();
        tick();
        checks++; if (feed !== 1'b1) begin failures++; $display("FAIL midop_feeding: got %0b expected 1", feed); end
        Nclr = 1'b0;
        tick();
        $display("mid-op reset: feed=%0b busy=%0b reg_r=%0d", feed, busy, reg_r);
        checks++; if (feed !== 1'b0 || busy !== 1'b0 || reg_r !== 7'd0) begin failures++; $display("FAIL midop_reset: got feed=%0b busy=%0b reg_r=%0d expected 0 0 0", feed, busy, reg_r); end
        Nclr = 1'b1;
        req = 1'b0;
        tick();
        model = 0;
    endtask

    initial begin
        test_reset();
        test_load_dispense();
        test_overflow();
        test_simultaneous();
        test_done_and_ack();
        test_empty();
        test_held_req_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
